// File: rtl/key_entry_ctrl.sv
// Keypad-to-display sequencing controller: editable right-aligned digit buffer,
// commit/view handling and blinking empty prompt. All outputs are registered.
module key_entry_ctrl #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [3:0]            KEY_Value,
  input  logic                  Value_en,
  output logic [4*DIGITS-1:0]   DISP_DATA,
  output logic [DIGITS-1:0]     DISP_MASK,
  output logic [4*DIGITS-1:0]   COMMIT_VAL,
  output logic [3:0]            COMMIT_CNT,
  output logic                  COMMIT_P,
  output logic                  OVF_P,
  output logic                  VIEW
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned BW = $clog2(BLINK_DIV);

  typedef enum logic {StEdit, StShow} state_e;

  state_e              state_q, state_d;
  logic [3:0]          key_q;
  logic                en_q;
  logic [W-1:0]        buf_q, buf_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        cval_q, cval_d;
  logic [CW-1:0]       ccnt_q, ccnt_d;
  logic [BW-1:0]       blink_q, blink_d;
  logic                phase_q, phase_d;
  logic                commit_p_q, commit_p_d;
  logic                ovf_p_q, ovf_p_d;
  logic [W-1:0]        disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   disp_mask_q, disp_mask_d;
  logic                accept;

  // Key events are registered first so that every output shows a key one full
  // cycle after it was sampled.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    cval_d     = cval_q;
    ccnt_d     = ccnt_q;
    commit_p_d = 1'b0;
    ovf_p_d    = 1'b0;
    accept     = 1'b0;

    if (blink_q == BW'(BLINK_DIV - 1)) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + BW'(1);
      phase_d = phase_q;
    end

    if (en_q) begin
      if (key_q <= 4'd9) begin
        if (cnt_q < CW'(DIGITS)) begin
          buf_d  = {buf_q[W-5:0], key_q};
          cnt_d  = cnt_q + CW'(1);
          accept = 1'b1;
        end else begin
          ovf_p_d = 1'b1;
        end
      end else begin
        case (key_q)
          4'hA: begin
            if (cnt_q != '0) begin
              buf_d  = {4'h0, buf_q[W-1:4]};
              cnt_d  = cnt_q - CW'(1);
              accept = 1'b1;
            end
          end
          4'hB: begin
            buf_d  = '0;
            cnt_d  = '0;
            accept = 1'b1;
          end
          4'hC: begin
            cval_d     = buf_q;
            ccnt_d     = cnt_q;
            commit_p_d = 1'b1;
            buf_d      = '0;
            cnt_d      = '0;
            accept     = 1'b1;
          end
          4'hD: begin
            state_d = (state_q == StEdit) ? StShow : StEdit;
            accept  = 1'b1;
          end
          default: ;
        endcase
      end
      // Any editing key drops back to the edit view; that alone counts as accepted.
      if (key_q <= 4'hC && state_q == StShow) begin
        state_d = StEdit;
        accept  = 1'b1;
      end
    end

    if (accept) begin
      blink_d = '0;
      phase_d = 1'b1;
    end

    disp_mask_d = '0;
    if (state_d == StShow) begin
      disp_data_d = cval_d;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        disp_mask_d[i] = (i < 32'(ccnt_d));
      end
      if (ccnt_d == '0) disp_mask_d[0] = 1'b1;
    end else if (cnt_d != '0) begin
      disp_data_d = buf_d;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        disp_mask_d[i] = (i < 32'(cnt_d));
      end
    end else begin
      disp_data_d    = '0;
      disp_mask_d[0] = phase_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StEdit;
      key_q       <= '0;
      en_q        <= 1'b0;
      buf_q       <= '0;
      cnt_q       <= '0;
      cval_q      <= '0;
      ccnt_q      <= '0;
      blink_q     <= '0;
      phase_q     <= 1'b1;
      commit_p_q  <= 1'b0;
      ovf_p_q     <= 1'b0;
      disp_data_q <= '0;
      disp_mask_q <= DIGITS'(1);
    end else begin
      state_q     <= state_d;
      key_q       <= KEY_Value;
      en_q        <= Value_en;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      cval_q      <= cval_d;
      ccnt_q      <= ccnt_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      commit_p_q  <= commit_p_d;
      ovf_p_q     <= ovf_p_d;
      disp_data_q <= disp_data_d;
      disp_mask_q <= disp_mask_d;
    end
  end

  assign DISP_DATA  = disp_data_q;
  assign DISP_MASK  = disp_mask_q;
  assign COMMIT_VAL = cval_q;
  assign COMMIT_CNT = 4'(ccnt_q);
  assign COMMIT_P   = commit_p_q;
  assign OVF_P      = ovf_p_q;
  assign VIEW       = (state_q == StShow);

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Scoreboard bench for key_entry_ctrl: a behavioural model queues the expected
// outputs per driven cycle; they are popped once the DUT's latency has elapsed.
module tb_key_entry_ctrl;

  localparam int DIGITS    = 8;
  localparam int BLINK_DIV = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  KEY_Value = 4'h0;
  logic        Value_en = 1'b0;
  logic [31:0] DISP_DATA;
  logic [7:0]  DISP_MASK;
  logic [31:0] COMMIT_VAL;
  logic [3:0]  COMMIT_CNT;
  logic        COMMIT_P;
  logic        OVF_P;
  logic        VIEW;

  key_entry_ctrl #(
    .DIGITS    (DIGITS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .KEY_Value  (KEY_Value),
    .Value_en   (Value_en),
    .DISP_DATA  (DISP_DATA),
    .DISP_MASK  (DISP_MASK),
    .COMMIT_VAL (COMMIT_VAL),
    .COMMIT_CNT (COMMIT_CNT),
    .COMMIT_P   (COMMIT_P),
    .OVF_P      (OVF_P),
    .VIEW       (VIEW)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  mask;
    logic [31:0] cval;
    logic [3:0]  ccnt;
    logic        cp;
    logic        ovf;
    logic        view;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_buf, m_cval;
  int          m_cnt, m_ccnt, m_blink;
  logic        m_view, m_phase;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_buf = '0; m_cval = '0; m_cnt = 0; m_ccnt = 0;
    m_blink = 0; m_view = 1'b0; m_phase = 1'b1;
  endtask

  // One clock of the model: applies the key (if any) and pushes the outputs it implies.
  task automatic model_tick(input logic [3:0] k, input logic en);
    exp_t e;
    logic acc, cp, ovf;
    acc = 1'b0; cp = 1'b0; ovf = 1'b0;
    if (en) begin
      if (k <= 4'd9) begin
        if (m_cnt < DIGITS) begin
          m_buf = {m_buf[27:0], k}; m_cnt++; acc = 1'b1;
        end else begin
          ovf = 1'b1;
        end
      end else if (k == 4'hA) begin
        if (m_cnt > 0) begin m_buf = m_buf >> 4; m_cnt--; acc = 1'b1; end
      end else if (k == 4'hB) begin
        m_buf = '0; m_cnt = 0; acc = 1'b1;
      end else if (k == 4'hC) begin
        m_cval = m_buf; m_ccnt = m_cnt; cp = 1'b1; m_buf = '0; m_cnt = 0; acc = 1'b1;
      end else if (k == 4'hD) begin
        m_view = !m_view; acc = 1'b1;
      end
      if (k <= 4'hC) begin
        if (m_view) acc = 1'b1;
        m_view = 1'b0;
      end
    end
    if (acc) begin
      m_blink = 0; m_phase = 1'b1;
    end else if (m_blink == BLINK_DIV - 1) begin
      m_blink = 0; m_phase = !m_phase;
    end else begin
      m_blink++;
    end
    if (m_view) begin
      e.data = m_cval;
      e.mask = (m_ccnt == 0) ? 8'h01 : 8'((1 << m_ccnt) - 1);
    end else if (m_cnt > 0) begin
      e.data = m_buf;
      e.mask = 8'((1 << m_cnt) - 1);
    end else begin
      e.data = '0;
      e.mask = {7'b0, m_phase};
    end
    e.cval = m_cval; e.ccnt = 4'(m_ccnt); e.cp = cp; e.ovf = ovf; e.view = m_view;
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] k, input logic en);
    exp_t e;
    KEY_Value = k;
    Value_en  = en;
    model_tick(k, en);
    @(posedge CLK);
    #1;
    check_eq("sb_depth", 64'(sb.size()), 64'd2);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("disp_data", DISP_DATA, e.data);
      check_eq("disp_mask", DISP_MASK, e.mask);
      check_eq("commit_val", COMMIT_VAL, e.cval);
      check_eq("commit_cnt", COMMIT_CNT, e.ccnt);
      check_eq("commit_p", COMMIT_P, e.cp);
      check_eq("ovf_p", OVF_P, e.ovf);
      check_eq("view", VIEW, e.view);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_data"}, DISP_DATA, 32'h0);
    check_eq({tag, "_mask"}, DISP_MASK, 8'h01);
    check_eq({tag, "_cval"}, COMMIT_VAL, 32'h0);
    check_eq({tag, "_ccnt"}, COMMIT_CNT, 4'h0);
    check_eq({tag, "_cp"}, COMMIT_P, 1'b0);
    check_eq({tag, "_ovf"}, OVF_P, 1'b0);
    check_eq({tag, "_view"}, VIEW, 1'b0);
  endtask

  // Release reset just after an edge; the first post-reset edge processes an idle slot.
  task automatic release_reset();
    @(posedge CLK);
    #1;
    sb.delete();
    model_reset();
    Value_en = 1'b0;
    RST = 1'b0;
    model_tick(4'h0, 1'b0);
  endtask

  task automatic keys(input logic [31:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) step(seq[4*i +: 4], 1'b1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_reset_vals("reset");
    release_reset();

    keys(32'h123, 3);
    step(4'h0, 1'b0);
    check_eq("t123_data", DISP_DATA[11:0], 12'h123);
    check_eq("t123_mask", DISP_MASK, 8'h07);

    step(4'hB, 1'b1);
    keys(32'h12345678, 8);
    step(4'h9, 1'b1);
    step(4'h0, 1'b0);
    check_eq("full_data", DISP_DATA, 32'h12345678);
    check_eq("full_ovf", OVF_P, 1'b1);
    step(4'h0, 1'b0);
    check_eq("full_ovf_clr", OVF_P, 1'b0);

    step(4'hB, 1'b1);
    keys(32'h45A, 3);
    step(4'h0, 1'b0);
    check_eq("bs_data", DISP_DATA, 32'h4);
    check_eq("bs_mask", DISP_MASK, 8'h01);
    step(4'hA, 1'b1);
    step(4'hA, 1'b1);
    repeat (14) step(4'h0, 1'b0);

    keys(32'h789C, 4);
    step(4'h0, 1'b0);
    check_eq("commit_val_789", COMMIT_VAL, 32'h789);
    check_eq("commit_cnt_3", COMMIT_CNT, 4'd3);
    keys(32'hD5, 2);
    step(4'h0, 1'b0);
    check_eq("after5_data", DISP_DATA, 32'h5);
    check_eq("after5_view", VIEW, 1'b0);

    step(4'hE, 1'b1);
    step(4'hF, 1'b1);
    for (int i = 0; i < 4; i++) step(4'(i * 5), 1'b0);
    step(4'hB, 1'b1);
    step(4'h0, 1'b0);
    check_eq("clear_keeps_commit", COMMIT_VAL, 32'h789);

    step(4'hC, 1'b1);
    step(4'hD, 1'b1);
    step(4'hC, 1'b1);
    step(4'h0, 1'b0);

    for (int i = 0; i < 80; i++) step(4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));

    step(4'hB, 1'b1);
    keys(32'h1C, 2);
    step(4'h0, 1'b0);
    check_eq("pre_rst_cp", COMMIT_P, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    check_reset_vals("async_rst");
    release_reset();
    step(4'h7, 1'b1);
    step(4'h0, 1'b0);
    step(4'hD, 1'b1);
    step(4'h0, 1'b0);
    repeat (3) step(4'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
